led_activity_monitor: RTL and testbench
=======================================

// Module: led_activity_monitor
// PURPOSE
//  Upstream feeder of the LED controller: turns raw TF-card and boot-ROM access events into the two
//  LED_IF state codes (Nextor activity, Boot activity) that the LED controller consumes.
//  Stretches short TF commands to a visible minimum on-time and runs a boot-phase state machine.
//  Boot ends on an explicit done strobe or on an idle timeout. Also keeps a saturating TF command counter for debug.
// PARAMETERS
//  MIN_ON        214_800      minimum Nextor ON time per TF command [clk] (10 ms @ 21.48 MHz); must be >= 1
//  BOOT_TIMEOUT  107_400_000  boot idle timeout [clk] (5 s); must be >= 1
//  CNT_W         16           width of AccessCount
// PORTS
//  CLK          in   1      drive clock
//  RESET        in   1      asynchronous, active-high reset
//  BootEnable   in   1      boot-ROM slot enabled (level)
//  BootAccess   in   1      1-clk strobe: boot-ROM read
//  BootDone     in   1      1-clk strobe: boot loader wrote completion register
//  TfReq        in   1      1-clk strobe: new TF card command issued
//  TfBusy       in   1      TF transaction in progress (level)
//  NextorState  out  2      LED state code: 2'd0 = OFF, 2'd1 = ON (codes 2,3 never driven)
//  BootState    out  2      same encoding
//  BootTimeout  out  1      sticky: boot phase ended by timeout
//  AccessCount  out  CNT_W  TF command count, saturating
// BEHAVIOUR
//  Reset (async, RESET=1): NextorState=OFF, BootState=OFF, BootTimeout=0, AccessCount=0, on_cnt=0,
//   boot FSM=B_IDLE, tmo_cnt=0. All outputs are registered; no combinational input->output path.
//  Nextor stretch, evaluated at every edge:
//   on_cnt <= TfReq ? MIN_ON : (on_cnt!=0 ? on_cnt-1 : 0)
//   NextorState <= (TfReq | TfBusy | on_cnt>1) ? ON : OFF
//   Result: a lone TfReq sampled at edge k gives ON for exactly MIN_ON cycles, after edges k..k+MIN_ON-1.
//   TfBusy extends ON, and OFF follows 1 cycle after TfBusy falls once on_cnt<=1.
//   A new TfReq during a stretch reloads on_cnt (retrigger, no accumulation).
//  AccessCount: +1 on each TfReq; holds at 2^CNT_W-1 (no wrap).
//  Boot FSM states and transitions:
//   B_IDLE  : BootEnable & BootAccess -> B_ACTIVE, tmo_cnt<=BOOT_TIMEOUT.
//   B_ACTIVE: BootDone -> B_DONE (has priority over a same-cycle BootAccess).
//             else !BootEnable -> B_IDLE.
//             else BootAccess -> reload tmo_cnt<=BOOT_TIMEOUT.
//             else tmo_cnt==1 -> B_DONE and BootTimeout<=1.
//             else tmo_cnt<=tmo_cnt-1.
//   B_DONE  : terminal until reset; BootAccess and BootDone are ignored.
//   BootState register <= ON iff next FSM state is B_ACTIVE, so BootState changes on the same edge as the FSM.
//   BootDone in B_IDLE is ignored.
//  Nextor path runs independently of the boot FSM; the LED controller arbitrates between the two states.
//  Reset asserted mid-stretch or mid-boot: immediate return to reset values.
// TESTING
//  1 MIN_ON=4: TfReq pulse at edge 10, TfBusy=0 -> NextorState ON after edges 10..13, OFF after edge 14.
//  2 TfReq at 10, TfBusy high edges 11..20 -> ON continuously, OFF after edge 21.
//    Second TfReq at 12 with MIN_ON=4 -> ON through edge 15 (retrigger).
//  3 CNT_W=2: 5 TfReq pulses -> AccessCount 1,2,3,3,3.
//  4 BOOT_TIMEOUT=8: BootEnable=1, BootAccess at 5 -> BootState ON. No further events -> OFF after edge 13.
//    BootTimeout=1, and a later BootAccess does not restart the boot phase.
//  5 BootAccess at 5, BootAccess+BootDone same edge 7 -> B_DONE, BootState OFF after edge 7, BootTimeout=0.
//    BootEnable dropped in B_ACTIVE -> B_IDLE; a new BootAccess re-enters B_ACTIVE.
//  6 Assert RESET asynchronously mid-stretch and mid-boot -> all outputs 0 without a clock edge.
//    After RESET release, a boot phase restarts normally.

Source files
------------

// File: rtl/led_activity_monitor_if.sv
// rtl/led_activity_monitor_if.sv - access events in, LED state codes and debug count out
// master drives the raw events; slave is the activity monitor.
interface led_activity_monitor_if #(
  parameter int CNT_W = 16
);
  logic             BootEnable;
  logic             BootAccess;
  logic             BootDone;
  logic             TfReq;
  logic             TfBusy;
  logic [1:0]       NextorState;
  logic [1:0]       BootState;
  logic             BootTimeout;
  logic [CNT_W-1:0] AccessCount;

  modport master (
    output BootEnable, BootAccess, BootDone, TfReq, TfBusy,
    input  NextorState, BootState, BootTimeout, AccessCount
  );

  modport slave (
    input  BootEnable, BootAccess, BootDone, TfReq, TfBusy,
    output NextorState, BootState, BootTimeout, AccessCount
  );
endinterface

// File: rtl/led_activity_monitor.sv
// rtl/led_activity_monitor.sv - TF activity stretcher, boot-phase FSM and TF command counter
// Produces registered LED state codes for the LED controller.
module led_activity_monitor #(
  parameter int MIN_ON       = 214_800,
  parameter int BOOT_TIMEOUT = 107_400_000,
  parameter int CNT_W        = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  led_activity_monitor_if.slave  bus
);

  localparam int ON_W  = $clog2(MIN_ON + 1);
  localparam int TMO_W = $clog2(BOOT_TIMEOUT + 1);

  localparam logic [1:0] LED_OFF = 2'd0;
  localparam logic [1:0] LED_ON  = 2'd1;

  typedef enum logic [1:0] {
    B_IDLE   = 2'd0,
    B_ACTIVE = 2'd1,
    B_DONE   = 2'd2
  } boot_state_t;

  logic [ON_W-1:0]  on_cnt_q,   on_cnt_d;
  logic [1:0]       nextor_q,   nextor_d;
  logic [CNT_W-1:0] acc_cnt_q,  acc_cnt_d;

  boot_state_t      boot_fsm_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [1:0]       boot_led_q;
  logic             boot_tmo_q;

  // on_cnt > 1 (not > 0) keeps a lone request lit for exactly MIN_ON cycles.
  always_comb begin
    on_cnt_d  = on_cnt_q;
    nextor_d  = LED_OFF;
    acc_cnt_d = acc_cnt_q;
    if (bus.TfReq) begin
      on_cnt_d = ON_W'(MIN_ON);
    end else if (on_cnt_q != '0) begin
      on_cnt_d = on_cnt_q - 1'b1;
    end
    if (bus.TfReq || bus.TfBusy || (on_cnt_q > ON_W'(1))) begin
      nextor_d = LED_ON;
    end
    if (bus.TfReq && (acc_cnt_q != {CNT_W{1'b1}})) begin
      acc_cnt_d = acc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      on_cnt_q  <= '0;
      nextor_q  <= LED_OFF;
      acc_cnt_q <= '0;
    end else begin
      on_cnt_q  <= on_cnt_d;
      nextor_q  <= nextor_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  // BootState is written alongside the state so it tracks the FSM on the same edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      boot_fsm_q <= B_IDLE;
      tmo_cnt_q  <= '0;
      boot_led_q <= LED_OFF;
      boot_tmo_q <= 1'b0;
    end else begin
      case (boot_fsm_q)
        B_IDLE: begin
          if (bus.BootEnable && bus.BootAccess) begin
            boot_fsm_q <= B_ACTIVE;
            tmo_cnt_q  <= TMO_W'(BOOT_TIMEOUT);
            boot_led_q <= LED_ON;
          end else begin
            boot_led_q <= LED_OFF;
          end
        end
        B_ACTIVE: begin
          if (bus.BootDone) begin
            boot_fsm_q <= B_DONE;
            boot_led_q <= LED_OFF;
          end else if (!bus.BootEnable) begin
            boot_fsm_q <= B_IDLE;
            boot_led_q <= LED_OFF;
          end else if (bus.BootAccess) begin
            tmo_cnt_q  <= TMO_W'(BOOT_TIMEOUT);
            boot_led_q <= LED_ON;
          end else if (tmo_cnt_q == TMO_W'(1)) begin
            boot_fsm_q <= B_DONE;
            boot_led_q <= LED_OFF;
            boot_tmo_q <= 1'b1;
          end else begin
            tmo_cnt_q  <= tmo_cnt_q - 1'b1;
            boot_led_q <= LED_ON;
          end
        end
        default: begin
          boot_fsm_q <= B_DONE;
          boot_led_q <= LED_OFF;
        end
      endcase
    end
  end

  assign bus.NextorState = nextor_q;
  assign bus.BootState   = boot_led_q;
  assign bus.BootTimeout = boot_tmo_q;
  assign bus.AccessCount = acc_cnt_q;

endmodule

// File: tb/tb_led_activity_monitor.sv
// tb/tb_led_activity_monitor.sv - scoreboard bench for led_activity_monitor
// Directed vectors push expected outputs; a monitor pops and compares one cycle at a time.
module tb_led_activity_monitor;

  logic clk;
  logic rst;

  led_activity_monitor_if #(.CNT_W(2)) bus ();

  led_activity_monitor #(
    .MIN_ON      (4),
    .BOOT_TIMEOUT(8),
    .CNT_W       (2)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [6:0] outs();
    return {bus.NextorState, bus.BootState, bus.BootTimeout, bus.AccessCount};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ns=%0d bs=%0d to=%0d cnt=%0d, expected ns=%0d bs=%0d to=%0d cnt=%0d",
               name, act[6:5], act[4:3], act[2], act[1:0], exp[6:5], exp[4:3], exp[2], exp[1:0]);
    end
  endtask

  // Monitor: every output update lands just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, outs(), e.exp);
      end
    end
  end

  task automatic drive(input logic en, input logic acc, input logic done,
                       input logic req, input logic busy);
    bus.BootEnable = en;
    bus.BootAccess = acc;
    bus.BootDone   = done;
    bus.TfReq      = req;
    bus.TfBusy     = busy;
  endtask

  // One clock: inputs, then the outputs expected after the edge.
  task automatic step(input string name,
                      input logic en, input logic acc, input logic done,
                      input logic req, input logic busy,
                      input logic [1:0] ns, input logic [1:0] bs,
                      input logic to, input logic [1:0] cnt);
    exp_t e;
    @(negedge clk);
    drive(en, acc, done, req, busy);
    e.name = name;
    e.exp  = {ns, bs, to, cnt};
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic reset_pulse(input string name);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check(name, outs(), 7'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), 7'd0);
    @(negedge clk);
    rst = 1'b0;

    // Saturating counter: 1,2,3,3,3 with back-to-back requests
    step("cnt1", 0,0,0,1,0, 1,0,0,1);
    step("cnt2", 0,0,0,1,0, 1,0,0,2);
    step("cnt3", 0,0,0,1,0, 1,0,0,3);
    step("cnt4", 0,0,0,1,0, 1,0,0,3);
    step("cnt5", 0,0,0,1,0, 1,0,0,3);
    for (int i = 0; i < 3; i++) step("cnt_tail_on", 0,0,0,0,0, 1,0,0,3);
    step("cnt_tail_off", 0,0,0,0,0, 0,0,0,3);

    reset_pulse("reset_after_cnt");

    // Lone request: ON for exactly 4 cycles
    step("lone_req", 0,0,0,1,0, 1,0,0,1);
    for (int i = 0; i < 3; i++) step("lone_on", 0,0,0,0,0, 1,0,0,1);
    step("lone_off", 0,0,0,0,0, 0,0,0,1);
    step("lone_idle", 0,0,0,0,0, 0,0,0,1);

    // Busy extends past the stretch; OFF one cycle after busy falls
    step("busy_req", 0,0,0,1,0, 1,0,0,2);
    for (int i = 0; i < 10; i++) step("busy_on", 0,0,0,0,1, 1,0,0,2);
    step("busy_off", 0,0,0,0,0, 0,0,0,2);

    // Retrigger reloads the stretch
    step("retrig_req1", 0,0,0,1,0, 1,0,0,3);
    step("retrig_gap", 0,0,0,0,0, 1,0,0,3);
    step("retrig_req2", 0,0,0,1,0, 1,0,0,3);
    for (int i = 0; i < 3; i++) step("retrig_on", 0,0,0,0,0, 1,0,0,3);
    step("retrig_off", 0,0,0,0,0, 0,0,0,3);

    // Boot timeout after 8 idle cycles, then terminal
    step("boot_idle_en", 1,0,0,0,0, 0,0,0,3);
    step("boot_access", 1,1,0,0,0, 0,1,0,3);
    for (int i = 0; i < 7; i++) step("boot_active", 1,0,0,0,0, 0,1,0,3);
    step("boot_timeout", 1,0,0,0,0, 0,0,1,3);
    step("boot_no_restart", 1,1,0,0,0, 0,0,1,3);
    step("boot_done_hold", 1,0,0,0,0, 0,0,1,3);

    reset_pulse("reset_after_timeout");

    // Done in idle ignored; done beats same-cycle access
    step("done_in_idle", 1,0,1,0,0, 0,0,0,0);
    step("bd_access", 1,1,0,0,0, 0,1,0,0);
    step("bd_active", 1,0,0,0,0, 0,1,0,0);
    step("bd_acc_and_done", 1,1,1,0,0, 0,0,0,0);
    step("bd_done_ignores_acc", 1,1,0,0,0, 0,0,0,0);

    reset_pulse("reset_after_done");

    // Enable dropped returns to idle; re-entry works
    step("en_access", 1,1,0,0,0, 0,1,0,0);
    step("en_drop", 0,0,0,0,0, 0,0,0,0);
    step("en_low_access", 0,1,0,0,0, 0,0,0,0);
    step("en_reenter", 1,1,0,0,0, 0,1,0,0);
    step("en_reload", 1,1,0,0,0, 0,1,0,0);
    step("en_done", 1,0,1,0,0, 0,0,0,0);

    reset_pulse("reset_before_async");

    // Asynchronous reset mid-stretch and mid-boot
    step("async_setup", 1,1,0,1,0, 1,1,0,1);
    step("async_mid", 1,0,0,0,0, 1,1,0,1);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", outs(), 7'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("async_reset_held", outs(), 7'd0);
    @(negedge clk);
    rst = 1'b0;

    step("restart_access", 1,1,0,0,0, 0,1,0,0);
    for (int i = 0; i < 7; i++) step("restart_active", 1,0,0,0,0, 0,1,0,0);
    step("restart_timeout", 1,0,0,0,0, 0,0,1,0);

    begin
      int guard = 0;
      while (sb.size() > 0 && guard < 20) begin
        @(posedge clk);
        guard++;
      end
      #2;
      if (sb.size() > 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain: %0d expected entries left, required 0", sb.size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
